// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit that sits beside the single-cycle ALU in EX.
// It executes MULT/MULTU with a shift-add engine and DIV/DIVU with a restoring
// divider. Each engine retires one bit per clock. The unit also holds the
// architectural HI/LO registers, which software writes through MTHI/MTLO.
//
// Ports
//   i_clk       clock; all state updates on the rising edge
//   i_rst       synchronous active-high reset
//   i_start     issue request; accepted only while o_busy is low
//   i_op        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_a         multiplicand / dividend
//   i_b         multiplier / divisor
//   i_wr_hi     MTHI write strobe
//   i_wr_lo     MTLO write strobe
//   i_wdata     MTHI/MTLO write data
//   o_busy      operation in flight (hazard logic stalls MFHI/MFLO on it)
//   o_done      one-cycle pulse: HI/LO were just updated by a mul/div
//   o_div_zero  qualifies o_done: the finished op was a divide by zero
//   o_hi        HI register
//   o_lo        LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ONE_2W    = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Two's complement negation at operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + ONE_W;
    endfunction

    // Two's complement negation at full product width.
    function automatic logic [ACC_W-1:0] neg_2w(input logic [ACC_W-1:0] v);
        neg_2w = ~v + ONE_2W;
    endfunction

    // Magnitude of an operand. The most negative value maps onto itself,
    // which reads correctly as its unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v,
                                               input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            mag_w = neg_w(v);
        end else begin
            mag_w = v;
        end
    endfunction

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic [ACC_W-1:0]   acc_r, acc_nx_s;      // mul: product:multiplier, div: remainder:quotient
    logic [WIDTH-1:0]   opnd_r, opnd_nx_s;    // multiplicand magnitude or divisor magnitude
    logic               is_div_r, is_div_nx_s;
    logic               neg_q_r, neg_q_nx_s;  // negate product / quotient at the end
    logic               neg_r_r, neg_r_nx_s;  // negate remainder at the end
    logic [WIDTH-1:0]   hi_r, hi_nx_s;
    logic [WIDTH-1:0]   lo_r, lo_nx_s;
    logic               done_r, done_nx_s;
    logic               div_zero_r, div_zero_nx_s;
    logic               busy_r;

    logic               start_ok_s;
    logic               zero_div_s;
    logic               is_signed_s;
    logic               last_step_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_ext_s;
    logic [WIDTH-1:0]   rem_diff_s;
    logic               rem_ge_s;
    logic [ACC_W-1:0]   mul_step_s;
    logic [ACC_W-1:0]   div_step_s;
    logic [ACC_W-1:0]   prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Issue qualification and divide-by-zero detection.
    always_comb begin
        start_ok_s  = (state_r == ST_IDLE) && i_start;
        is_signed_s = i_op[0];
        zero_div_s  = start_ok_s && i_op[1] && (i_b == ZERO_W);
        last_step_s = (cnt_r == LAST_STEP);
    end

    // Single-bit engine steps and the final sign correction.
    always_comb begin
        // Shift-add: the carry out of the upper-half add becomes the new MSB.
        mul_sum_s = {1'b0, acc_r[ACC_W-1:WIDTH]} + {1'b0, opnd_r};
        if (acc_r[0]) begin
            mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else begin
            mul_step_s = {1'b0, acc_r[ACC_W-1:1]};
        end

        // Restoring divide: the shifted remainder needs WIDTH+1 bits. A kept
        // difference is always below the divisor, so WIDTH bits hold it.
        rem_ext_s  = acc_r[ACC_W-1:WIDTH-1];
        rem_ge_s   = (rem_ext_s >= {1'b0, opnd_r});
        rem_diff_s = rem_ext_s[WIDTH-1:0] - opnd_r;
        if (rem_ge_s) begin
            div_step_s = {rem_diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {acc_r[ACC_W-2:0], 1'b0};
        end

        if (neg_q_r) begin
            prod_fix_s = neg_2w(acc_r);
            quo_fix_s  = neg_w(acc_r[WIDTH-1:0]);
        end else begin
            prod_fix_s = acc_r;
            quo_fix_s  = acc_r[WIDTH-1:0];
        end

        if (neg_r_r) begin
            rem_fix_s = neg_w(acc_r[ACC_W-1:WIDTH]);
        end else begin
            rem_fix_s = acc_r[ACC_W-1:WIDTH];
        end
    end

    // Next-state logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s && !zero_div_s) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_step_s) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_FIX: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        cnt_nx_s      = cnt_r;
        acc_nx_s      = acc_r;
        opnd_nx_s     = opnd_r;
        is_div_nx_s   = is_div_r;
        neg_q_nx_s    = neg_q_r;
        neg_r_nx_s    = neg_r_r;
        hi_nx_s       = hi_r;
        lo_nx_s       = lo_r;
        done_nx_s     = 1'b0;
        div_zero_nx_s = div_zero_r;
        case (state_r)
            ST_IDLE: begin
                if (zero_div_s) begin
                    // Divide by zero completes at once and leaves HI/LO alone.
                    done_nx_s     = 1'b1;
                    div_zero_nx_s = 1'b1;
                end else if (start_ok_s) begin
                    cnt_nx_s    = CNT_ZERO;
                    is_div_nx_s = i_op[1];
                    neg_q_nx_s  = is_signed_s && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    neg_r_nx_s  = is_signed_s && i_a[WIDTH-1];
                    if (i_op[1]) begin
                        opnd_nx_s = mag_w(i_b, is_signed_s);
                        acc_nx_s  = {ZERO_W, mag_w(i_a, is_signed_s)};
                    end else begin
                        opnd_nx_s = mag_w(i_a, is_signed_s);
                        acc_nx_s  = {ZERO_W, mag_w(i_b, is_signed_s)};
                    end
                end else begin
                    // MTHI/MTLO only land when no issue is accepted this cycle.
                    if (i_wr_hi) begin
                        hi_nx_s = i_wdata;
                    end else begin
                        hi_nx_s = hi_r;
                    end
                    if (i_wr_lo) begin
                        lo_nx_s = i_wdata;
                    end else begin
                        lo_nx_s = lo_r;
                    end
                end
            end
            ST_CALC: begin
                cnt_nx_s = cnt_r + CNT_ONE;
                if (is_div_r) begin
                    acc_nx_s = div_step_s;
                end else begin
                    acc_nx_s = mul_step_s;
                end
            end
            ST_FIX: begin
                done_nx_s     = 1'b1;
                div_zero_nx_s = 1'b0;
                cnt_nx_s      = CNT_ZERO;
                if (is_div_r) begin
                    lo_nx_s = quo_fix_s;
                    hi_nx_s = rem_fix_s;
                end else begin
                    lo_nx_s = prod_fix_s[WIDTH-1:0];
                    hi_nx_s = prod_fix_s[ACC_W-1:WIDTH];
                end
            end
            default: begin
                done_nx_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath, HI/LO and handshake registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r      <= CNT_ZERO;
            acc_r      <= {ACC_W{1'b0}};
            opnd_r     <= ZERO_W;
            is_div_r   <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_nx_s;
            acc_r      <= acc_nx_s;
            opnd_r     <= opnd_nx_s;
            is_div_r   <= is_div_nx_s;
            neg_q_r    <= neg_q_nx_s;
            neg_r_r    <= neg_r_nx_s;
            hi_r       <= hi_nx_s;
            lo_r       <= lo_nx_s;
            done_r     <= done_nx_s;
            div_zero_r <= div_zero_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
        end
    end

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_div_zero = div_zero_r;
    assign o_hi       = hi_r;
    assign o_lo       = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit at WIDTH=32. Inputs change just after the
// falling edge and outputs are sampled on the falling edge. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_wr_hi;
    logic        i_wr_lo;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_div_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int n_checks;
    int n_fail;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_wr_hi    (i_wr_hi),
        .i_wr_lo    (i_wr_lo),
        .i_wdata    (i_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: present one issue for exactly one rising edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Wait for o_done. lat counts rising edges after the accepting edge when
    // called right after issue(); busy_cnt counts sampled busy cycles.
    task automatic wait_done(output int lat, output int busy_cnt);
        int k;
        k        = 1;
        busy_cnt = 0;
        while (!o_done && k < 100) begin
            if (o_busy) busy_cnt = busy_cnt + 1;
            @(negedge clk);
            k = k + 1;
        end
        if (!o_done) check_eq("done_timeout", {63'd0, o_done}, 64'd1);
        lat = k - 1;
    endtask

    initial begin
        int lat;
        int bc;
        int seen;

        n_checks = 0;
        n_fail   = 0;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        i_op     = 2'b00;
        i_a      = 32'd0;
        i_b      = 32'd0;
        i_wr_hi  = 1'b0;
        i_wr_lo  = 1'b0;
        i_wdata  = 32'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("rst_done", {63'd0, o_done}, 64'd0);
        check_eq("rst_dz",   {63'd0, o_div_zero}, 64'd0);
        check_eq("rst_hi",   {32'd0, o_hi}, 64'd0);
        check_eq("rst_lo",   {32'd0, o_lo}, 64'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // MULTU all-ones squared: latency and busy window.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check_eq("multu_lat",  64'(lat), 64'd33);
        check_eq("multu_busy", 64'(bc), 64'd33);
        check_eq("multu_busy_at_done", {63'd0, o_busy}, 64'd0);
        check_eq("multu_hi",   {32'd0, o_hi}, 64'hFFFF_FFFE);
        check_eq("multu_lo",   {32'd0, o_lo}, 64'h0000_0001);
        check_eq("multu_dz",   {63'd0, o_div_zero}, 64'd0);
        @(negedge clk);
        check_eq("done_one_cycle", {63'd0, o_done}, 64'd0);

        // MULT -3 x 5 = -15.
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bc);
        check_eq("mult_hi", {32'd0, o_hi}, 64'hFFFF_FFFF);
        check_eq("mult_lo", {32'd0, o_lo}, 64'hFFFF_FFF1);

        // MULT -4 x -6 = 24.
        issue(2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
        wait_done(lat, bc);
        check_eq("mult_nn_hi", {32'd0, o_hi}, 64'd0);
        check_eq("mult_nn_lo", {32'd0, o_lo}, 64'd24);

        // DIV -7 / 2 -> q=-3, r=-1.
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        check_eq("div_lo", {32'd0, o_lo}, 64'hFFFF_FFFD);
        check_eq("div_hi", {32'd0, o_hi}, 64'hFFFF_FFFF);

        // DIV 7 / -2 -> q=-3, r=1 (remainder follows dividend sign).
        issue(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat, bc);
        check_eq("div_pn_lo", {32'd0, o_lo}, 64'hFFFF_FFFD);
        check_eq("div_pn_hi", {32'd0, o_hi}, 64'd1);

        // DIVU 100 / 7 -> 14 r 2.
        issue(2'b10, 32'd100, 32'd7);
        wait_done(lat, bc);
        check_eq("divu_lat", 64'(lat), 64'd33);
        check_eq("divu_lo",  {32'd0, o_lo}, 64'd14);
        check_eq("divu_hi",  {32'd0, o_hi}, 64'd2);

        // DIV most-negative / -1 truncates, no exception.
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        check_eq("divmin_lo", {32'd0, o_lo}, 64'h8000_0000);
        check_eq("divmin_hi", {32'd0, o_hi}, 64'd0);
        check_eq("divmin_dz", {63'd0, o_div_zero}, 64'd0);

        // DIVU 100 / 0: done next cycle, HI/LO untouched.
        issue(2'b10, 32'd100, 32'd0);
        wait_done(lat, bc);
        check_eq("dz_lat",  64'(lat), 64'd0);
        check_eq("dz_busy", 64'(bc), 64'd0);
        check_eq("dz_flag", {63'd0, o_div_zero}, 64'd1);
        check_eq("dz_hi",   {32'd0, o_hi}, 64'd0);
        check_eq("dz_lo",   {32'd0, o_lo}, 64'h8000_0000);
        @(negedge clk);
        check_eq("dz_no_busy", {63'd0, o_busy}, 64'd0);

        // Start and MTHI during busy are ignored.
        issue(2'b00, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        i_start = 1'b1;
        i_op    = 2'b10;
        i_a     = 32'd9;
        i_b     = 32'd4;
        i_wr_hi = 1'b1;
        i_wdata = 32'h1234;
        @(negedge clk);
        i_start = 1'b0;
        i_wr_hi = 1'b0;
        wait_done(lat, bc);
        check_eq("busy_ign_hi", {32'd0, o_hi}, 64'd0);
        check_eq("busy_ign_lo", {32'd0, o_lo}, 64'd42);
        @(negedge clk);
        check_eq("no_queued_start", {63'd0, o_busy}, 64'd0);

        // MTHI while idle.
        i_wr_hi = 1'b1;
        i_wdata = 32'h1234;
        @(negedge clk);
        i_wr_hi = 1'b0;
        check_eq("mthi_hi", {32'd0, o_hi}, 64'h1234);
        check_eq("mthi_lo", {32'd0, o_lo}, 64'd42);

        // Start and MTLO in the same idle cycle: MTLO dropped.
        i_start = 1'b1;
        i_op    = 2'b00;
        i_a     = 32'd2;
        i_b     = 32'd2;
        i_wr_lo = 1'b1;
        i_wdata = 32'hDEAD;
        @(negedge clk);
        i_start = 1'b0;
        i_wr_lo = 1'b0;
        check_eq("mtlo_dropped", {32'd0, o_lo}, 64'd42);
        check_eq("start_won",    {63'd0, o_busy}, 64'd1);
        wait_done(lat, bc);
        check_eq("start_won_lo", {32'd0, o_lo}, 64'd4);

        // Reset ten cycles into a MULT aborts with no result.
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        repeat (9) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check_eq("abort_busy", {63'd0, o_busy}, 64'd0);
        check_eq("abort_hi",   {32'd0, o_hi}, 64'd0);
        check_eq("abort_lo",   {32'd0, o_lo}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_done) seen = seen + 1;
            @(negedge clk);
        end
        check_eq("abort_no_done", 64'(seen), 64'd0);
        issue(2'b00, 32'd6, 32'd7);
        wait_done(lat, bc);
        check_eq("post_rst_lo", {32'd0, o_lo}, 64'd42);
        check_eq("post_rst_hi", {32'd0, o_hi}, 64'd0);

        // Back-to-back issue in the done cycle.
        issue(2'b00, 32'd2, 32'd3);
        wait_done(lat, bc);
        check_eq("b2b_first_lo", {32'd0, o_lo}, 64'd6);
        issue(2'b10, 32'd9, 32'd4);
        check_eq("b2b_busy", {63'd0, o_busy}, 64'd1);
        wait_done(lat, bc);
        check_eq("b2b_lat", 64'(lat), 64'd33);
        check_eq("b2b_lo",  {32'd0, o_lo}, 64'd2);
        check_eq("b2b_hi",  {32'd0, o_hi}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
